arbitro_trasmision: RTL and testbench

Round-robin arbiter and sequencer that shares the single serial byte transmitter between NREQ requesters.
It selects one pending request and latches its byte. It then drives the transmitter's start/data handshake, watches its ready line until the frame completes, and reports per-requester accept and completion pulses.
It sits between the producer blocks and the transmitter instance.

---
 rtl/arbitro_trasmision_pkg.sv | 28 ++
 rtl/arbitro_trasmision_selector_rr.sv | 34 +++
 rtl/arbitro_trasmision.sv | 126 ++++++++++++
 tb/tb_arbitro_trasmision.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_trasmision_pkg.sv
// Shared definitions for the transmit arbiter: state encoding, default sizing
// and the pointer-width helper used by the top and its selector.
package arbitro_trasmision_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LAUNCH = ST_LAUNCH,
    SEND   = ST_SEND
  } state_t;

  localparam int DEFAULT_NREQ         = 4;
  localparam int DEFAULT_BUSY_TIMEOUT = 15;

  // Bits needed to encode 0..value-1; never less than 1 so every field has a wire.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/arbitro_trasmision_selector_rr.sv
// Combinational round-robin pick: first set request searching upward from ptr,
// wrapping modulo NREQ.
module arbitro_trasmision_selector_rr
  import arbitro_trasmision_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   id
);

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return PW'(sum);
  endfunction

  always_comb begin
    valid = 1'b0;
    id    = '0;
    // Walk from the farthest offset back towards ptr so the closest set bit wins.
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[wrap_add(ptr, off)]) begin
        valid = 1'b1;
        id    = wrap_add(ptr, off);
      end
    end
  end

endmodule

// File: rtl/arbitro_trasmision.sv
// Round-robin arbiter/sequencer sharing one serial byte transmitter between
// NREQ requesters: grant, latch byte, launch, wait for frame end, report.
//
// Handshake: a requester holds req[i] high with stable data until ack[i]
// pulses; tx_start is held while LAUNCH lasts and dropped once tx_ready=0 is
// seen; tx_ready returning high ends the frame and produces done[id].
module arbitro_trasmision
  import arbitro_trasmision_pkg::*;
#(
  parameter int NREQ         = DEFAULT_NREQ,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output state_t            dbg_state
);

  localparam int            PW       = clog2(NREQ);
  localparam int            CW       = clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;

  logic            sel_valid;
  logic [PW-1:0]   sel_id;

  arbitro_trasmision_selector_rr #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_selector_rr (
    .req   (req),
    .ptr   (ptr_q),
    .valid (sel_valid),
    .id    (sel_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A transmitter still busy from before a reset blocks new grants.
        if (tx_ready && sel_valid) begin
          id_d    = sel_id;
          data_d  = req_data[int'(sel_id)*8 +: 8];
          ptr_d   = (int'(sel_id) == NREQ - 1) ? '0 : sel_id + PW'(1);
          cnt_d   = '0;
          ack_d   = NREQ'(1) << sel_id;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!tx_ready) begin
          state_d = SEND;
        end else if (cnt_q == CNT_LAST) begin
          // Transmitter never went busy: abandon the frame without a done.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEND: begin
        if (tx_ready) begin
          done_d  = NREQ'(1) << id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign tx_start  = (state_q == LAUNCH);
  assign tx_data   = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_arbitro_trasmision.sv
// Bench for arbitro_trasmision: frame-level reference model compared every
// cycle, grant-order scoreboard and directed scenarios with literal expectations.
module tb_arbitro_trasmision;
  import arbitro_trasmision_pkg::*;

  localparam int NREQ         = 4;
  localparam int BUSY_TIMEOUT = 15;
  localparam int TX_AUTO      = 0;
  localparam int TX_MANUAL    = 1;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic              err;
  logic              busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_ready;
  state_t            dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         exp_id_q[$];

  int         tx_mode, drop_after, busy_len, busy_left, start_cnt;
  logic       start_seen;
  logic [NREQ-1:0] hold, drop_mask;
  int         n_ack, n_done, n_err, n_start, last_done_id;

  int         m_phase, m_owner, m_ptr, m_launch_n, m_ack, m_done;
  logic [7:0] m_byte;
  logic       m_err;
  bit         model_on = 1'b0;

  arbitro_trasmision #(
    .NREQ         (NREQ),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) idx = (idx == -1) ? i : -2;
    end
    return idx;
  endfunction

  // ---------------- transmitter model ----------------
  initial forever begin
    @(negedge clk);
    start_seen = tx_start;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (tx_mode == TX_AUTO) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_ready = 1'b1;
      end else if (start_seen === 1'b1 && tx_ready) begin
        start_cnt++;
        if (start_cnt >= drop_after) begin
          tx_ready  = 1'b0;
          busy_left = busy_len;
          start_cnt = 0;
        end
      end else begin
        start_cnt = 0;
      end
    end
  end

  // ---------------- requesters: drop req after ack unless held ----------------
  initial forever begin
    @(negedge clk);
    drop_mask = ack & ~hold;
  end

  initial forever begin
    @(posedge clk);
    #1;
    req = req & ~drop_mask;
  end

  // ---------------- frame-level reference model ----------------
  initial forever begin
    @(posedge clk);
    m_ack  = -1;
    m_done = -1;
    m_err  = 1'b0;
    if (rst) begin
      m_phase    = 0;
      m_owner    = 0;
      m_ptr      = 0;
      m_launch_n = 0;
      m_byte     = 8'h00;
      model_on   = 1'b1;
    end else if (model_on) begin
      case (m_phase)
        0: if (tx_ready && req != 0) begin
             m_owner = -1;
             for (int k = 0; k < NREQ; k++) begin
               if (m_owner < 0 && req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
             end
             m_byte     = req_data[8*m_owner +: 8];
             m_ptr      = (m_owner + 1) % NREQ;
             m_ack      = m_owner;
             m_launch_n = 0;
             m_phase    = 1;
           end
        1: begin
             m_launch_n++;
             if (!tx_ready) m_phase = 2;
             else if (m_launch_n == BUSY_TIMEOUT) begin
               m_err   = 1'b1;
               m_phase = 0;
             end
           end
        2: if (tx_ready) begin
             m_done  = m_owner;
             m_phase = 0;
           end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare and scoreboard ----------------
  initial forever begin
    logic [7:0] eb;
    int         ei;
    @(negedge clk);
    if (model_on) begin
      check("ack", ack, (m_ack >= 0) ? (1 << m_ack) : 0);
      check("done", done, (m_done >= 0) ? (1 << m_done) : 0);
      check("err", err, m_err);
      check("busy", busy, m_phase != 0);
      check("tx_start", tx_start, m_phase == 1);
      check("tx_data", tx_data, m_byte);
      if (ack != 0) begin
        check("ack_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          eb = exp_q.pop_front();
          ei = exp_id_q.pop_front();
          check("grant_id", onehot_idx(ack), ei);
          check("grant_byte", tx_data, eb);
        end
      end
      if (ack != 0) n_ack++;
      if (done != 0) begin
        n_done++;
        last_done_id = onehot_idx(done);
      end
      if (err) n_err++;
      if (tx_start) n_start++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic clear_counts();
    n_ack   = 0;
    n_done  = 0;
    n_err   = 0;
    n_start = 0;
  endtask

  task automatic expect_grant(input int id, input logic [7:0] b);
    exp_id_q.push_back(id);
    exp_q.push_back(b);
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_ack < target && k < budget) begin
      sample();
      k++;
    end
    check(name, n_ack >= target, 1);
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      sample();
      k++;
    end
    check(name, n_done >= target, 1);
  endtask

  task automatic wait_errs(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_err < target && k < budget) begin
      sample();
      k++;
    end
    check(name, n_err >= target, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int k;
    rst        = 1'b0;
    req        = '0;
    req_data   = '0;
    hold       = '0;
    tx_mode    = TX_AUTO;
    drop_after = 1;
    busy_len   = 20;
    busy_left  = 0;
    start_cnt  = 0;
    tx_ready   = 1'b1;
    clear_counts();
    last_done_id = -1;

    tick();
    do_reset(2);
    sample();
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // single request from requester 2
    tick();
    req_data[23:16] = 8'h41;
    expect_grant(2, 8'h41);
    clear_counts();
    req = 4'b0100;
    wait_dones(1, 60, "t1_done_timeout");
    check("t1_done_id", last_done_id, 2);
    check("t1_done_pulse", done, 4'b0100);
    check("t1_ack_count", n_ack, 1);
    check("t1_start_cycles", n_start, 2);
    check("t1_tx_data", tx_data, 8'h41);
    sample();
    check("t1_busy_after", busy, 0);
    check("t1_done_one_cycle", done, 0);

    // fairness with all requests held
    tick();
    do_reset(1);
    busy_len = 3;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    expect_grant(0, 8'h10);
    expect_grant(1, 8'h11);
    expect_grant(2, 8'h12);
    expect_grant(3, 8'h13);
    expect_grant(0, 8'h10);
    expect_grant(1, 8'h11);
    clear_counts();
    hold = 4'b1111;
    req  = 4'b1111;
    wait_acks(6, 200, "t2_ack_timeout");
    tick();
    req  = '0;
    hold = '0;
    wait_dones(6, 60, "t2_done_timeout");
    check("t2_ack_count", n_ack, 6);
    check("t2_done_count", n_done, 6);
    check("t2_last_done", last_done_id, 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // transmitter never goes busy
    tick();
    do_reset(1);
    tx_mode  = TX_MANUAL;
    tx_ready = 1'b1;
    req_data = {8'h33, 8'h32, 8'h31, 8'h30};
    expect_grant(1, 8'h31);
    expect_grant(2, 8'h32);
    clear_counts();
    req = 4'b0110;
    wait_errs(1, 40, "t3_err_timeout");
    check("t3_start_cycles", n_start, 15);
    check("t3_err_pulse", err, 1);
    check("t3_no_done", n_done, 0);
    check("t3_start_low_at_err", tx_start, 0);
    wait_acks(2, 5, "t3_regrant_timeout");
    tick();
    tx_ready = 1'b0;
    repeat (3) tick();
    tx_ready = 1'b1;
    wait_dones(1, 10, "t3_done_timeout");
    check("t3_done_id", last_done_id, 2);
    check("t3_err_count", n_err, 1);

    // reset in the middle of a frame
    tick();
    do_reset(1);
    tx_mode   = TX_AUTO;
    busy_left = 0;
    start_cnt = 0;
    tx_ready  = 1'b1;
    busy_len  = 20;
    req_data[7:0] = 8'h77;
    expect_grant(0, 8'h77);
    clear_counts();
    req = 4'b0001;
    wait_acks(1, 10, "t4_ack_timeout");
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    check("t4_rst_tx_start", tx_start, 0);
    check("t4_rst_ack", ack, 0);
    check("t4_rst_done", done, 0);
    check("t4_rst_err", err, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_tx_data", tx_data, 8'h00);
    tick();
    clear_counts();
    req_data[7:0] = 8'h78;
    expect_grant(0, 8'h78);
    req = 4'b0001;
    k = 0;
    while (tx_ready == 1'b0 && k < 30) begin
      sample();
      k++;
    end
    check("t4_ready_timeout", tx_ready, 1);
    check("t4_no_ack_while_busy", n_ack, 0);
    sample();
    check("t4_ack_after_ready", ack, 4'b0001);
    wait_dones(1, 40, "t4_done_timeout");
    check("t4_done_id", last_done_id, 0);
    check("t4_done_count", n_done, 1);

    // transmitter busy while requester waits in idle
    tick();
    tx_mode  = TX_MANUAL;
    tx_ready = 1'b0;
    req_data[31:24] = 8'hC3;
    expect_grant(3, 8'hC3);
    clear_counts();
    req = 4'b1000;
    repeat (10) sample();
    check("t5_no_ack", n_ack, 0);
    check("t5_no_start", n_start, 0);
    tick();
    tx_ready = 1'b1;
    sample();
    check("t5_no_ack_same_cycle", ack, 0);
    sample();
    check("t5_ack3", ack, 4'b1000);
    tick();
    tx_ready = 1'b0;
    repeat (2) tick();
    tx_ready = 1'b1;
    wait_dones(1, 10, "t5_done_timeout");
    check("t5_done_id", last_done_id, 3);

    // request data changing after the grant must not reach the transmitter
    tick();
    tx_mode   = TX_AUTO;
    busy_left = 0;
    start_cnt = 0;
    tx_ready  = 1'b1;
    busy_len  = 8;
    req_data[7:0] = 8'hA5;
    expect_grant(0, 8'hA5);
    clear_counts();
    req = 4'b0001;
    wait_acks(1, 10, "t6_ack_timeout");
    tick();
    req_data[7:0] = 8'h5A;
    k = 0;
    while (n_done < 1 && k < 40) begin
      sample();
      check("t6_tx_data_hold", tx_data, 8'hA5);
      k++;
    end
    check("t6_done_timeout", n_done, 1);
    check("t6_done_id", last_done_id, 0);

    tick();
    req_data = '0;
    repeat (3) sample();
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
